// File: rtl/ace_pkg.sv
// Shared ACE CCU types: snoop address index and default conflict-table depth.
// Used by the snoop interconnect and the conflict manager.
package ace_pkg;

    localparam int unsigned CmAddrWidth  = 12;
    localparam int unsigned CmNumEntries = 4;

    typedef logic [CmAddrWidth-1:0] cm_addr_t;

endpackage

// File: rtl/ace_ccu_cm_match.sv
// Parallel comparator of the snoop index against every valid table slot.
// Purely combinational; produces a single hit flag.
module ace_ccu_cm_match #(
    parameter int unsigned AddrWidth  = 12,
    parameter int unsigned NumEntries = 4
) (
    input  logic [NumEntries-1:0][AddrWidth-1:0] slots_i,
    input  logic [NumEntries-1:0]                valids_i,
    input  logic [AddrWidth-1:0]                 addr_i,
    output logic                                 hit_o
);

    logic [NumEntries-1:0] eq;

    always_comb begin
        eq = '0;
        for (int k = 0; k < NumEntries; k++) begin
            eq[k] = valids_i[k] && (slots_i[k] == addr_i);
        end
    end

    assign hit_o = |eq;

endmodule

// File: rtl/ace_ccu_conflict_manager.sv
// Snoop conflict manager: in-order table of in-flight snoop indices.
// Optional stall statistics counter enabled by ACE_CCU_CM_STATS_EN.
module ace_ccu_conflict_manager
    import ace_pkg::*;
#(
    parameter int unsigned AddrWidth  = CmAddrWidth,
    parameter int unsigned NumEntries = CmNumEntries,
    parameter int unsigned CntWidth   = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cm_valid_i,
    input  logic                          cm_ready_i,
    input  logic [AddrWidth-1:0]          cm_addr_i,
    output logic                          cm_stall_o,
    input  logic                          cm_done_i,
    output logic [$clog2(NumEntries):0]   occupancy_o,
    output logic                          err_o,
    output logic [CntWidth-1:0]           stall_cnt_o
);

    localparam int unsigned PtrW = $clog2(NumEntries);
    localparam int unsigned OccW = PtrW + 1;

    logic [NumEntries-1:0][AddrWidth-1:0] slot_q;
    logic [NumEntries-1:0]                valid_q;
    logic [PtrW-1:0]                      wr_q;
    logic [PtrW-1:0]                      rd_q;
    logic [OccW-1:0]                      cnt_q;
    logic                                 err_q;
    logic                                 hit;
    logic                                 full;
    logic                                 alloc;
    logic                                 free;

    ace_ccu_cm_match #(
        .AddrWidth  (AddrWidth),
        .NumEntries (NumEntries)
    ) u_match (
        .slots_i  (slot_q),
        .valids_i (valid_q),
        .addr_i   (cm_addr_i),
        .hit_o    (hit)
    );

    assign full  = (cnt_q == OccW'(NumEntries));
    // Reset blocks the ac path; otherwise no ready/done in this path.
    assign cm_stall_o = rst_i || (cm_valid_i && (hit || full));
    assign alloc = cm_valid_i && cm_ready_i && !cm_stall_o;
    assign free  = cm_done_i && (cnt_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q  <= '0;
            valid_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (alloc) begin
                slot_q[wr_q]  <= cm_addr_i;
                valid_q[wr_q] <= 1'b1;
                wr_q          <= wr_q + PtrW'(1);
            end
            if (free) begin
                valid_q[rd_q] <= 1'b0;
                rd_q          <= rd_q + PtrW'(1);
            end
            unique case ({alloc, free})
                2'b10:   cnt_q <= cnt_q + OccW'(1);
                2'b01:   cnt_q <= cnt_q - OccW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (cm_done_i && (cnt_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign occupancy_o = cnt_q;
    assign err_o       = err_q;

`ifdef ACE_CCU_CM_STATS_EN
    logic [CntWidth-1:0] stall_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (cm_stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CntWidth'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ace_ccu_conflict_manager.sv
// Directed vector bench for ace_ccu_conflict_manager.
// Stall counter expectation follows ACE_CCU_CM_STATS_EN.
module tb_ace_ccu_conflict_manager;

    localparam int AW = 12;
    localparam int NE = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cm_valid;
    logic          cm_ready;
    logic [AW-1:0] cm_addr;
    logic          cm_stall;
    logic          cm_done;
    logic [2:0]    occupancy;
    logic          err;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    ace_ccu_conflict_manager #(
        .AddrWidth  (AW),
        .NumEntries (NE),
        .CntWidth   (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cm_valid_i  (cm_valid),
        .cm_ready_i  (cm_ready),
        .cm_addr_i   (cm_addr),
        .cm_stall_o  (cm_stall),
        .cm_done_i   (cm_done),
        .occupancy_o (occupancy),
        .err_o       (err),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic          ready;
        logic [AW-1:0] addr;
        logic          done;
        logic          exp_stall;
        logic [2:0]    exp_occ;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic r, input logic [AW-1:0] a,
                       input logic d, input logic s, input logic [2:0] o,
                       input logic e);
        vec_t t;
        t.valid = v; t.ready = r; t.addr = a; t.done = d;
        t.exp_stall = s; t.exp_occ = o; t.exp_err = e;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic v, input logic r, input logic [AW-1:0] a,
                         input logic d);
        @(negedge clk);
        cm_valid = v; cm_ready = r; cm_addr = a; cm_done = d;
        #1;
    endtask

    initial begin
        logic [CW-1:0] exp_cnt;

        rst = 1'b1;
        cm_valid = 1'b0; cm_ready = 1'b0; cm_addr = '0; cm_done = 1'b0;
        #3;
        chk("reset_stall", 64'(cm_stall), 64'd1);
        chk("reset_occ", 64'(occupancy), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        //  v  r  addr    d  stall occ err
        add(0, 0, 12'h000, 0, 0, 0, 0);
        add(1, 1, 12'h010, 0, 0, 0, 0);
        add(1, 1, 12'h010, 0, 1, 1, 0);
        add(1, 1, 12'h010, 1, 1, 1, 0);
        add(1, 1, 12'h010, 0, 0, 0, 0);
        add(0, 1, 12'h000, 0, 0, 1, 0);
        add(0, 0, 12'h000, 1, 0, 1, 0);
        add(0, 0, 12'h000, 0, 0, 0, 0);
        add(1, 1, 12'h001, 0, 0, 0, 0);
        add(1, 1, 12'h002, 0, 0, 1, 0);
        add(1, 1, 12'h003, 0, 0, 2, 0);
        add(1, 1, 12'h004, 0, 0, 3, 0);
        add(1, 1, 12'h005, 0, 1, 4, 0);
        add(1, 1, 12'h005, 1, 1, 4, 0);
        add(1, 1, 12'h005, 0, 0, 3, 0);
        add(0, 0, 12'h000, 1, 0, 4, 0);
        add(1, 0, 12'h001, 0, 0, 3, 0);
        add(1, 0, 12'h002, 0, 0, 3, 0);
        add(1, 0, 12'h003, 0, 1, 3, 0);
        add(1, 1, 12'h006, 0, 0, 3, 0);
        add(1, 1, 12'h007, 1, 1, 4, 0);
        add(1, 1, 12'h007, 0, 0, 3, 0);
        add(0, 0, 12'h000, 1, 0, 4, 0);
        add(0, 0, 12'h000, 1, 0, 3, 0);
        add(0, 0, 12'h000, 1, 0, 2, 0);
        add(0, 0, 12'h000, 1, 0, 1, 0);
        add(0, 0, 12'h000, 0, 0, 0, 0);
        add(0, 0, 12'h000, 1, 0, 0, 0);
        add(0, 0, 12'h000, 0, 0, 0, 1);
        add(1, 0, 12'h000, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].ready, vecs[i].addr, vecs[i].done);
            chk($sformatf("v%0d_stall", i), 64'(cm_stall), 64'(vecs[i].exp_stall));
            chk($sformatf("v%0d_occ", i), 64'(occupancy), 64'(vecs[i].exp_occ));
            chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
        end

        // Mid-cycle async reset clears sticky error and table.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst1_err", 64'(err), 64'd0);
        chk("rst1_occ", 64'(occupancy), 64'd0);
        chk("rst1_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Hold a conflicting snoop for seven stalled cycles.
        drive(1, 1, 12'h020, 0);
        chk("st_first", 64'(cm_stall), 64'd0);
        for (int c = 0; c < 7; c++) begin
            drive(1, 1, 12'h020, 0);
            chk($sformatf("st_hold%0d", c), 64'(cm_stall), 64'd1);
        end
        drive(0, 0, 12'h000, 0);
`ifdef ACE_CCU_CM_STATS_EN
        exp_cnt = 7;
`else
        exp_cnt = 0;
`endif
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
        chk("st_occ", 64'(occupancy), 64'd1);

        // Reset asserted while a snoop is stalled.
        drive(1, 1, 12'h020, 0);
        chk("pre_rst_stall", 64'(cm_stall), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst2_stall", 64'(cm_stall), 64'd1);
        chk("rst2_occ", 64'(occupancy), 64'd0);
        chk("rst2_cnt", 64'(stall_cnt), 64'd0);
        chk("rst2_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_stall", 64'(cm_stall), 64'd0);
        drive(0, 0, 12'h000, 0);
        chk("post_rst_occ", 64'(occupancy), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
